// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative 32x32 multiply / divide unit for a processor HI/LO
//               pair. Shift-add multiply and restoring divide, one bit per
//               cycle over 32 cycles, followed by a one-cycle sign fix-up.
//               Optional divide datapath is enabled by macro MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // acc holds the 64-bit product while multiplying, or {remainder, quotient}
    // while dividing; b_reg holds the operand-b magnitude.
    logic [63:0] acc;
    logic [31:0] b_reg;
    logic [4:0]  iter_cnt;
    logic        is_div;
    logic        neg_lo;
    logic        neg_hi;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        short_op;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] acc_neg;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[31];
    assign b_neg     = is_signed & b[31];
    // The magnitude of 32'h80000000 is itself when read as unsigned, which
    // is exactly what the unsigned iterations need.
    assign a_mag     = a_neg ? (32'd0 - a) : a;
    assign b_mag     = b_neg ? (32'd0 - b) : b;

`ifdef MULDIV_DIV_EN
    // Only a zero divisor bypasses the iterations.
    assign short_op  = op[1] & (b == 32'd0);
`else
    // Without the divide datapath every divide completes immediately.
    assign short_op  = op[1];
`endif

    // Multiply step: conditionally add multiplicand to the upper half, then
    // shift the whole accumulator right, consuming one multiplier bit.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_reg} : 33'd0);
    assign mul_step  = {mul_sum, acc[31:1]};
    assign acc_neg   = 64'd0 - acc;

`ifdef MULDIV_DIV_EN
    logic [32:0] div_diff;
    logic [63:0] div_step;
    // Restoring step: shift {rem, dividend} left by one and try subtracting
    // the divisor; a non-negative difference yields quotient bit 1.
    assign div_diff  = acc[63:31] - {1'b0, b_reg};
    assign div_step  = div_diff[32] ? {acc[62:0], 1'b0}
                                    : {div_diff[31:0], acc[30:0], 1'b1};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = short_op ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (iter_cnt == 5'd31) begin
                    state_nxt = SIGN;
                end
            end
            SIGN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= 64'd0;
            b_reg       <= 32'd0;
            iter_cnt    <= 5'd0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc         <= {32'd0, a_mag};
                        b_reg       <= b_mag;
                        iter_cnt    <= 5'd0;
                        is_div      <= op[1];
                        // Quotient and product take sign(a)^sign(b);
                        // remainder follows the dividend.
                        neg_lo      <= a_neg ^ b_neg;
                        neg_hi      <= op[1] ? a_neg : (a_neg ^ b_neg);
                        div_by_zero <= 1'b0;
                        if (short_op) begin
`ifdef MULDIV_DIV_EN
                            hi          <= a;
                            lo          <= 32'hFFFF_FFFF;
                            div_by_zero <= 1'b1;
`else
                            hi          <= 32'd0;
                            lo          <= 32'd0;
`endif
                        end
                    end
                end
                RUN: begin
                    iter_cnt <= iter_cnt + 5'd1;
`ifdef MULDIV_DIV_EN
                    acc      <= is_div ? div_step : mul_step;
`else
                    acc      <= mul_step;
`endif
                end
                SIGN: begin
                    if (is_div) begin
                        hi <= neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
                        lo <= neg_lo ? (32'd0 - acc[31:0])  : acc[31:0];
                    end else begin
                        {hi, lo} <= neg_lo ? acc_neg : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
